mont_exp_ctrl: RTL and testbench
================================

# mont_exp_ctrl

Left-to-right binary modular exponentiation controller that sits directly upstream of the 512-bit Montgomery multiplier. It drives the multiplier's start/operand ports and consumes its result/done. Given a base already in Montgomery form, the Montgomery form of one, an exponent and its bit length, it issues a fixed sequence of Montgomery squarings and multiplications and returns the normal-domain result.

## Interface

Parameters:
- `N`, 512: operand width; must equal the multiplier width.
- `TW`, 10: width of the exponent-length input.

Ports (`mul_*` ports connect to the multiplier):
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `in_x` input N: base in Montgomery form, X·R mod M.
- `in_r` input N: R mod M, the Montgomery one.
- `in_e` input N: exponent.
- `in_t` input TW: exponent bit count, 0..512; values above 512 are clamped to 512.
- `in_m` input N: odd modulus.
- `result` output N: X^E mod M, normal domain; held until the next accepted start.
- `done` output 1: one-cycle pulse when `result` is valid.
- `busy` output 1: high from the cycle after an accepted start until the cycle after `done`.
- `mul_start` output 1: one-cycle pulse to the multiplier.
- `mul_a` output N: multiplier operand A.
- `mul_b` output N: multiplier operand B.
- `mul_m` output N: modulus to the multiplier.
- `mul_result` input N: multiplier product, valid when `mul_done` is high.
- `mul_done` input 1: multiplier completion; level or pulse, only the first high cycle after a `mul_start` counts.

## Operation

Registers:
- `x_q`, `e_q`, `m_q`: captured in LOAD.
- `acc`: N bits, reset to 0.
- `idx`: TW bits, current exponent bit.

FSM states: IDLE, LOAD, SQ_GO, SQ_WAIT, ML_GO, ML_WAIT, PO_GO, PO_WAIT, FIN.
- IDLE → LOAD on `start`. In LOAD: capture operands, set `acc` = `in_r`, set `idx` = min(`in_t`, 512).
- LOAD → PO_GO if `idx` == 0, else SQ_GO with `idx` decremented by 1.
- SQ_GO: assert `mul_start`, with `mul_a` = `mul_b` = `acc`. Go to SQ_WAIT.
- SQ_WAIT on `mul_done`: `acc` ← `mul_result`.
  - To ML_GO if `e_q[idx]` is 1.
  - Else to SQ_GO (with `idx` − 1) if `idx` > 0.
  - Else to PO_GO.
- ML_GO: `mul_start`, with `mul_a` = `acc` and `mul_b` = `x_q`. Go to ML_WAIT.
- ML_WAIT on `mul_done`: `acc` ← `mul_result`. Then SQ_GO (with `idx` − 1) if `idx` > 0, else PO_GO.
- PO_GO: `mul_start`, with `mul_a` = `acc` and `mul_b` = 1. This converts out of Montgomery form. Go to PO_WAIT.
- PO_WAIT on `mul_done`: `result` ← `mul_result`. Go to FIN.
- FIN: `done` = 1. Go to IDLE.

Rules:
- Total multiplier calls = t + popcount(e[t−1:0]) + 1.
- `mul_a`, `mul_b` and `mul_m` are registered. They stay stable from the `mul_start` cycle through the `mul_done` cycle, because the multiplier samples operands while it is idle.
- `start` during `busy` is ignored; there is no queuing.
- `mul_done` outside a WAIT state is ignored.
- `in_*` may change freely after LOAD.
- Exponent bits at or above `in_t` are ignored.

## Timing

- Reset (asynchronous, any state): FSM to IDLE. `result`, `acc`, `mul_a`, `mul_b` and `mul_m` = 0. `done`, `busy` and `mul_start` = 0. Reset aborts an in-flight multiplication without waiting for `mul_done`.
- `start` high at edge k → LOAD in cycle k+1 → first `mul_start` in cycle k+2.
- Controller overhead per call: 1 GO cycle, plus the multiplier latency L counted from `mul_start` to `mul_done`, plus 1 cycle.
- `done` asserts the cycle after the final `mul_done`. Worst case (t = 512, e all ones): 1025 calls.
- `mul_start` is never asserted in two consecutive cycles, and never while a WAIT state is pending.
- `busy` falls together with the IDLE entry after FIN. A `start` in that same cycle is accepted.

## Test plan

For these checks, M = 13 and the bench multiplier model returns a·b·R⁻¹ mod M (R = 2^512) after 5 cycles.

- Nominal: X = 3·R mod 13, E = 5, t = 3 → result = 9 (3^5 mod 13). Exactly 6 `mul_start` pulses; `done` is a single cycle.
- Zero length: t = 0, E = 0xFF → result = 1, exactly 1 multiplier call (the post-conversion). Bits above t are ignored.
- Worst case: t = 512 (and separately t = 700, clamped), E = 2^512−1, X = 2·R mod 13 → 1025 calls; result = 2^(2^512−1) mod 13 per the reference model.
- Handshake: multiplier latency randomised 1..600 cycles, with `mul_done` held high for 3 cycles. Operands stay stable through each WAIT, extra `mul_done` cycles are ignored, and the result is unchanged.
- Start while busy: a second `start` mid-run with different operands → first result unaffected; no second run; `busy` stays high; `done` pulses once.
- Reset mid-operation: assert `resetn` = 0 asynchronously mid-run (between clock edges) → outputs zero immediately; `mul_start` stays 0; a fresh start after release gives 9 for the nominal vector.

Source files
------------

// File: rtl/mont_exp_ctrl_if.sv
// Operand/result bus between the exponentiation controller and the Montgomery multiplier.
// The controller is the master; the multiplier is the slave.
interface mont_exp_ctrl_if #(
    parameter int N = 512
);
    logic         mul_start;
    logic [N-1:0] mul_a;
    logic [N-1:0] mul_b;
    logic [N-1:0] mul_m;
    logic [N-1:0] mul_result;
    logic         mul_done;

    modport master (
        output mul_start, mul_a, mul_b, mul_m,
        input  mul_result, mul_done
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_m,
        output mul_result, mul_done
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation controller in front of a Montgomery multiplier.
// Squares/multiplies in Montgomery form, then multiplies by 1 to return the normal-domain result.
module mont_exp_ctrl #(
    parameter int N  = 512,
    parameter int TW = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_r,
    input  logic [N-1:0]  in_e,
    input  logic [TW-1:0] in_t,
    input  logic [N-1:0]  in_m,
    output logic [N-1:0]  result,
    output logic          done,
    output logic          busy,
    mont_exp_ctrl_if.master mul
);
    localparam int            IW    = $clog2(N);
    localparam logic [TW-1:0] T_MAX = TW'(N);

    typedef enum logic [3:0] {
        IDLE, LOAD, SQ_GO, SQ_WAIT, ML_GO, ML_WAIT, PO_GO, PO_WAIT, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  e_q, e_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [TW-1:0] idx_q, idx_d;
    logic [N-1:0]  result_q, result_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          mul_start_q, mul_start_d;
    logic [N-1:0]  mul_a_q, mul_a_d;
    logic [N-1:0]  mul_b_q, mul_b_d;
    logic [N-1:0]  mul_m_q, mul_m_d;

    logic [TW-1:0] t_clamp;
    logic [IW-1:0] bit_sel;

    assign t_clamp = (in_t > T_MAX) ? T_MAX : in_t;
    assign bit_sel = idx_q[IW-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            e_q         <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_m_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            e_q         <= e_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_m_q     <= mul_m_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        e_d      = e_q;
        m_d      = m_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                x_d   = in_x;
                e_d   = in_e;
                m_d   = in_m;
                acc_d = in_r;
                idx_d = t_clamp;
                if (t_clamp != '0) begin
                    idx_d   = t_clamp - TW'(1);
                    state_d = SQ_GO;
                end else begin
                    state_d = PO_GO;
                end
            end
            SQ_GO: state_d = SQ_WAIT;
            SQ_WAIT: begin
                if (mul.mul_done) begin
                    acc_d = mul.mul_result;
                    if (e_q[bit_sel]) begin
                        state_d = ML_GO;
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - TW'(1);
                        state_d = SQ_GO;
                    end else begin
                        state_d = PO_GO;
                    end
                end
            end
            ML_GO: state_d = ML_WAIT;
            ML_WAIT: begin
                if (mul.mul_done) begin
                    acc_d = mul.mul_result;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - TW'(1);
                        state_d = SQ_GO;
                    end else begin
                        state_d = PO_GO;
                    end
                end
            end
            PO_GO: state_d = PO_WAIT;
            PO_WAIT: begin
                if (mul.mul_done) begin
                    result_d = mul.mul_result;
                    state_d  = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are loaded on entry to a GO state from the next-state values,
    // then held untouched until the following GO state.
    always_comb begin
        mul_start_d = (state_d == SQ_GO) || (state_d == ML_GO) || (state_d == PO_GO);
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_m_d     = mul_m_q;
        case (state_d)
            SQ_GO: begin
                mul_a_d = acc_d;
                mul_b_d = acc_d;
                mul_m_d = m_d;
            end
            ML_GO: begin
                mul_a_d = acc_d;
                mul_b_d = x_d;
                mul_m_d = m_d;
            end
            PO_GO: begin
                mul_a_d = acc_d;
                mul_b_d = N'(1);
                mul_m_d = m_d;
            end
            default: ;
        endcase
        done_d = (state_d == FIN);
        busy_d = (state_d != IDLE);
    end

    assign result        = result_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign mul.mul_start = mul_start_q;
    assign mul.mul_a     = mul_a_q;
    assign mul.mul_b     = mul_b_q;
    assign mul.mul_m     = mul_m_q;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier mod 13, result/call-count scoreboard,
// operand-stability and mul_start spacing monitors.
module tb_mont_exp_ctrl;
    localparam int N   = 512;
    localparam int TW  = 10;
    localparam int MOD = 13;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [N-1:0]  in_x, in_r, in_e, in_m;
    logic [TW-1:0] in_t;
    logic [N-1:0]  result;
    logic          done;
    logic          busy;

    mont_exp_ctrl_if #(.N(N)) mif ();

    mont_exp_ctrl #(.N(N), .TW(TW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_x   (in_x),
        .in_r   (in_r),
        .in_e   (in_e),
        .in_t   (in_t),
        .in_m   (in_m),
        .result (result),
        .done   (done),
        .busy   (busy),
        .mul    (mif.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int rmod, rinv;

    logic [N-1:0] exp_q[$];
    int           calls_q[$];

    int call_cnt = 0, done_cnt = 0, mon_err = 0, stab_err = 0;
    int call_base, done_base, mon_base, stab_base;
    logic prev_start = 1'b0;

    int lat_min = 5, lat_max = 5, hold = 1;
    int m_phase, m_wcnt, m_hcnt;
    logic chk_first;
    logic [N-1:0] cap_a, cap_b, cap_m;

    function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b);
        int ai, bi;
        ai = int'(a % N'(MOD));
        bi = int'(b % N'(MOD));
        return N'((((ai * bi) % MOD) * rinv) % MOD);
    endfunction

    // Right-to-left reference in the normal domain.
    function automatic int ref_exp(input int base, input logic [N-1:0] e, input int t);
        int tc, r, b;
        tc = (t > N) ? N : t;
        r = 1;
        b = base % MOD;
        for (int i = 0; i < tc; i++) begin
            if (e[i]) r = (r * b) % MOD;
            b = (b * b) % MOD;
        end
        return r;
    endfunction

    function automatic int ref_calls(input logic [N-1:0] e, input int t);
        int tc, pc;
        tc = (t > N) ? N : t;
        pc = 0;
        for (int i = 0; i < tc; i++) if (e[i]) pc++;
        return tc + pc + 1;
    endfunction

    // Multiplier model: accepts a start whenever not computing, drops a held done on a new start.
    always @(posedge clk or negedge resetn) begin
        int lat;
        if (!resetn) begin
            m_phase       <= 0;
            m_wcnt        <= 0;
            m_hcnt        <= 0;
            chk_first     <= 1'b0;
            mif.mul_done   <= 1'b0;
            mif.mul_result <= '0;
        end else begin
            if (m_phase == 1 || (m_phase == 2 && chk_first)) begin
                if (mif.mul_a !== cap_a || mif.mul_b !== cap_b || mif.mul_m !== cap_m)
                    stab_err <= stab_err + 1;
            end
            chk_first <= 1'b0;
            if (mif.mul_start && m_phase == 1) begin
                stab_err <= stab_err + 1;
            end else if (mif.mul_start) begin
                lat   = int'($urandom_range(lat_max, lat_min));
                cap_a <= mif.mul_a;
                cap_b <= mif.mul_b;
                cap_m <= mif.mul_m;
                if (lat <= 1) begin
                    mif.mul_done   <= 1'b1;
                    mif.mul_result <= mont(mif.mul_a, mif.mul_b);
                    m_hcnt         <= hold - 1;
                    m_phase        <= 2;
                    chk_first      <= 1'b1;
                end else begin
                    mif.mul_done <= 1'b0;
                    m_wcnt       <= lat - 1;
                    m_phase      <= 1;
                end
            end else if (m_phase == 1) begin
                if (m_wcnt == 1) begin
                    mif.mul_done   <= 1'b1;
                    mif.mul_result <= mont(cap_a, cap_b);
                    m_hcnt         <= hold - 1;
                    m_phase        <= 2;
                    chk_first      <= 1'b1;
                end else begin
                    m_wcnt <= m_wcnt - 1;
                end
            end else if (m_phase == 2) begin
                if (m_hcnt == 0) begin
                    mif.mul_done <= 1'b0;
                    m_phase      <= 0;
                end else begin
                    m_hcnt <= m_hcnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (mif.mul_start) begin
                call_cnt++;
                if (prev_start) mon_err++;
            end
            if (done) done_cnt++;
            prev_start = mif.mul_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic launch(input int base, input logic [N-1:0] e, input int t, input bit now);
        if (!now) @(negedge clk);
        in_x  = N'((base * rmod) % MOD);
        in_r  = N'(rmod);
        in_e  = e;
        in_t  = TW'(t);
        in_m  = N'(MOD);
        start = 1'b1;
        exp_q.push_back(N'(ref_exp(base, e, t)));
        calls_q.push_back(ref_calls(e, t));
        call_base = call_cnt;
        done_base = done_cnt;
        mon_base  = mon_err;
        stab_base = stab_err;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_x = '1;
        in_e = '0;
        in_r = '0;
        in_m = N'(7);
        in_t = '0;
    endtask

    task automatic finish_op(input string name);
        int n, budget, exp_c;
        logic [N-1:0] exp_r;
        exp_r  = exp_q.pop_front();
        exp_c  = calls_q.pop_front();
        budget = exp_c * (lat_max + 2) + 20;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
            return;
        end
        checks++;
        if (result !== exp_r) begin
            failures++;
            $display("FAIL %s_result: got %0d expected %0d", name, result, exp_r);
        end
        checks++;
        if (call_cnt - call_base != exp_c) begin
            failures++;
            $display("FAIL %s_calls: got %0d expected %0d", name, call_cnt - call_base, exp_c);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_cnt - done_base != 1) begin
            failures++;
            $display("FAIL %s_done_pulse: pulses %0d done_now %b expected 1 pulse", name,
                     done_cnt - done_base, done);
        end
        checks++;
        if (stab_err != stab_base || mon_err != mon_base) begin
            failures++;
            $display("FAIL %s_handshake: stability errs %0d spacing errs %0d expected 0", name,
                     stab_err - stab_base, mon_err - mon_base);
        end
        $display("txn %s: result=%0d calls=%0d", name, result, call_cnt - call_base);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        in_x = '0; in_r = '0; in_e = '0; in_m = '0; in_t = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || mif.mul_start !== 1'b0 ||
            mif.mul_a !== '0 || mif.mul_b !== '0 || mif.mul_m !== '0) begin
            failures++;
            $display("FAIL reset_state: result=%0d done=%b busy=%b mul_start=%b expected all 0",
                     result, done, busy, mif.mul_start);
        end
        resetn = 1'b1;
        @(negedge clk);
        $display("txn reset: outputs idle");
    endtask

    task automatic test_nominal();
        launch(3, N'(5), 3, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL nominal_busy: got %b expected 1", busy);
        end
        finish_op("nominal");
        launch(7, N'(11), 3, 1'b0);
        finish_op("upper_bit_ignored");
        launch(5, N'(6), 4, 1'b0);
        finish_op("pattern_5_6");
        launch(4, N'(12'hA5F), 12, 1'b0);
        finish_op("pattern_4_a5f");
    endtask

    task automatic test_zero_len();
        launch(3, N'(8'hFF), 0, 1'b0);
        finish_op("zero_len");
    endtask

    task automatic test_worst();
        launch(2, '1, 512, 1'b0);
        finish_op("worst_512");
        launch(2, '1, 700, 1'b0);
        finish_op("worst_700_clamped");
    endtask

    task automatic test_handshake();
        lat_min = 1;
        lat_max = 600;
        hold    = 3;
        launch(3, N'(5), 3, 1'b0);
        finish_op("handshake_nominal");
        launch(6, N'(13), 4, 1'b0);
        finish_op("handshake_6_13");
        lat_min = 1;
        lat_max = 1;
        launch(3, N'(5), 3, 1'b0);
        finish_op("handshake_lat1");
        lat_min = 5;
        lat_max = 5;
        hold    = 1;
    endtask

    task automatic test_start_busy();
        int c0;
        launch(3, N'(5), 3, 1'b0);
        repeat (15) @(negedge clk);
        in_x  = N'((10 * rmod) % MOD);
        in_e  = N'(9);
        in_t  = TW'(4);
        in_r  = N'(rmod);
        in_m  = N'(MOD);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL start_busy_level: got %b expected 1", busy);
        end
        finish_op("start_while_busy");
        c0 = call_cnt;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || call_cnt != c0) begin
            failures++;
            $display("FAIL start_busy_no_rerun: busy=%b extra calls=%0d expected 0/0", busy,
                     call_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        launch(3, N'(5), 3, 1'b0);
        finish_op("b2b_first");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_fall: got %b expected 0", busy);
        end
        launch(2, N'(7), 3, 1'b1);
        finish_op("b2b_second");
    endtask

    task automatic test_reset_mid();
        launch(3, N'(5), 3, 1'b0);
        void'(exp_q.pop_front());
        void'(calls_q.pop_front());
        repeat (10) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || mif.mul_start !== 1'b0 ||
            mif.mul_a !== '0 || mif.mul_b !== '0 || mif.mul_m !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: result=%0d busy=%b mul_start=%b expected zeros",
                     result, busy, mif.mul_start);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mif.mul_start !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_hold: mul_start=%b busy=%b expected 0", mif.mul_start,
                         busy);
            end
        end
        resetn = 1'b1;
        $display("txn reset_mid: aborted");
        launch(3, N'(5), 3, 1'b0);
        finish_op("after_reset");
    endtask

    initial begin
        logic [N:0] rfull;
        rfull    = '0;
        rfull[N] = 1'b1;
        rmod     = int'(rfull % (N + 1)'(MOD));
        rinv     = 0;
        for (int k = 1; k < MOD; k++) if ((rmod * k) % MOD == 1) rinv = k;

        test_reset();
        test_nominal();
        test_zero_len();
        test_worst();
        test_handshake();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
